// File: rtl/traffic_down_timer_pkg.sv
// Purpose : shared types and defaults for the traffic-light phase timer.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: timer_state_t FSM encoding, default width/divider, prescaler width helper.
package traffic_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam int TIMER_WIDTH_DEF    = 5;
    localparam int TIMER_TICK_DIV_DEF = 4;

    // A divide-by-1 prescaler still needs one flop so the port widths stay legal.
    function automatic int prescaler_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/traffic_down_timer_if.sv
// Purpose : load handshake plus status bundle for traffic_down_timer.
// Latency : n/a (wires only).
// Backpr. : load_ready from the timer gates load_valid from the controller.
// Ports   : master = phase controller side, slave = timer side.
//           pause exists only when TIMER_PAUSE_EN is defined.
interface traffic_down_timer_if
    import traffic_timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH_DEF
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_n;
    logic             busy;
    logic             done;
`ifdef TIMER_PAUSE_EN
    logic             pause;

    modport master (
        output load_valid, load_value, abort, pause,
        input  load_ready, count, count_n, busy, done
    );
    modport slave (
        input  load_valid, load_value, abort, pause,
        output load_ready, count, count_n, busy, done
    );
`else
    modport master (
        output load_valid, load_value, abort,
        input  load_ready, count, count_n, busy, done
    );
    modport slave (
        input  load_valid, load_value, abort,
        output load_ready, count, count_n, busy, done
    );
`endif
endinterface

// File: rtl/traffic_tick_prescaler.sv
// Purpose : divides clk into one decrement tick every TICK_DIV enabled cycles.
// Latency : tick is combinational from the internal count and enable.
// Backpr. : enable low freezes the count; clear forces it back to 0.
// Ports   : clk, rst_n, clear, enable in; tick out.
module traffic_tick_prescaler
    import traffic_timer_pkg::*;
#(
    parameter int TICK_DIV = TIMER_TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int            PW   = prescaler_width(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    assign tick = enable && (presc_q == LAST);

    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
        end else if (enable) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/traffic_down_timer.sv
// Purpose : loadable down-counter timing one traffic-light phase; pulses done at zero.
// Latency : load N at edge E -> DONE entered at E+N*TICK_DIV, done high the cycle after (N=0: cycle after E).
// Backpr. : load_ready only in IDLE; load_valid elsewhere is ignored.
// Ports   : clk, rst_n (async active-low), tif (slave: load handshake, abort, count/count_n/busy/done).
// Config  : TIMER_PAUSE_EN adds tif.pause, which freezes prescaler and count while in RUN.
module traffic_down_timer
    import traffic_timer_pkg::*;
#(
    parameter int WIDTH    = TIMER_WIDTH_DEF,
    parameter int TICK_DIV = TIMER_TICK_DIV_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    traffic_down_timer_if.slave   tif
);
    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick;
    logic             pause_in;
    logic             presc_clear;
    logic             presc_enable;

`ifdef TIMER_PAUSE_EN
    assign pause_in = tif.pause;
`else
    assign pause_in = 1'b0;
`endif

    // Prescaler only runs in RUN; holding it clear elsewhere guarantees a fresh
    // full TICK_DIV period after every load, and abort resets it immediately.
    assign presc_enable = (state_q == RUN) && !pause_in;
    assign presc_clear  = (state_q != RUN) || tif.abort;

    traffic_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (presc_clear),
        .enable (presc_enable),
        .tick   (tick)
    );

    // State and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state and next-count logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                // abort has no effect here, so a simultaneous load still goes through.
                if (tif.load_valid) begin
                    if (tif.load_value != '0) begin
                        state_d = RUN;
                        count_d = tif.load_value;
                    end else begin
                        state_d = DONE;
                        count_d = '0;
                    end
                end
            end
            RUN: begin
                if (tif.abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (tick && (count_q != '0)) begin
                    // Zero guard keeps the count from ever wrapping to all ones.
                    count_d = count_q - 1'b1;
                    if (count_q == WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                count_d = '0;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Outputs decoded purely from registers.
    always_comb begin
        tif.load_ready = (state_q == IDLE);
        tif.busy       = (state_q == RUN);
        tif.done       = (state_q == DONE);
        tif.count      = count_q;
        tif.count_n    = ~count_q;
    end

endmodule
